// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI sink: opcodes, framebuffer address width
// and decoder state encoding.
package oled_pkg;

    localparam int unsigned FbAddrW = 10;

    localparam logic [7:0] OpAddrMode    = 8'h20;
    localparam logic [7:0] OpColAddr     = 8'h21;
    localparam logic [7:0] OpPageAddr    = 8'h22;
    localparam logic [7:0] OpSetContrast = 8'h81;
    localparam logic [7:0] OpChargePump  = 8'h8D;
    localparam logic [7:0] OpMuxRatio    = 8'hA8;
    localparam logic [7:0] OpDisplayOff  = 8'hAE;
    localparam logic [7:0] OpDisplayOn   = 8'hAF;
    localparam logic [7:0] OpDispOffset  = 8'hD3;
    localparam logic [7:0] OpClkDiv      = 8'hD5;
    localparam logic [7:0] OpPrecharge   = 8'hD9;
    localparam logic [7:0] OpComPins     = 8'hDA;
    localparam logic [7:0] OpVcomDesel   = 8'hDB;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArg1 = 2'd1,
        StArg2 = 2'd2
    } state_e;

    // Opcodes followed by exactly one argument that the sink consumes.
    function automatic logic is_one_arg_op(input logic [7:0] op);
        return (op == OpAddrMode)   || (op == OpSetContrast) || (op == OpChargePump) ||
               (op == OpMuxRatio)   || (op == OpDispOffset)  || (op == OpClkDiv)     ||
               (op == OpPrecharge)  || (op == OpComPins)     || (op == OpVcomDesel);
    endfunction

    function automatic logic is_two_arg_op(input logic [7:0] op);
        return (op == OpColAddr) || (op == OpPageAddr);
    endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// Pin-level bundle between an OLED write master and the framebuffer sink.
interface oled_spi_sink_if;
    import oled_pkg::*;

    logic               oled_sclk;
    logic               oled_mosi;
    logic               oled_dc;
    logic               oled_rst;
    logic               fb_wren;
    logic [FbAddrW-1:0] fb_wraddress;
    logic [7:0]         fb_data;
    logic               cmd_valid;
    logic [7:0]         cmd_byte;
    logic               display_on;
    logic [7:0]         contrast;

    modport master (
        output oled_sclk, oled_mosi, oled_dc, oled_rst,
        input  fb_wren, fb_wraddress, fb_data, cmd_valid, cmd_byte, display_on, contrast
    );

    modport slave (
        input  oled_sclk, oled_mosi, oled_dc, oled_rst,
        output fb_wren, fb_wraddress, fb_data, cmd_valid, cmd_byte, display_on, contrast
    );

endinterface

// File: rtl/spi_rx_byte.sv
// SPI mode-0 byte receiver: synchronizes the async pins into clk, detects SCLK
// rising edges and assembles MSB-first bytes with the DC bit sampled on bit 8.
module spi_rx_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       dc_i,
    input  logic       panel_rst_ni,
    output logic [7:0] data_o,
    output logic       dc_o,
    output logic       valid_o,
    output logic       link_up_o
);

    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] dc_q;
    logic [2:0] prst_q;
    logic [7:0] shift_q;
    logic [2:0] cnt_q;
    logic [7:0] data_q;
    logic       dc_out_q;
    logic       valid_q;
    logic       rise;
    logic [7:0] shift_next;

    // prst_q[2] is last cycle's synchronized reset, so an edge landing on the
    // release cycle is rejected.
    assign rise       = sclk_q[1] & ~sclk_q[2] & prst_q[1] & prst_q[2];
    assign shift_next = {shift_q[6:0], mosi_q[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q   <= '0;
            mosi_q   <= '0;
            dc_q     <= '0;
            prst_q   <= '1;
            shift_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            dc_out_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk_i};
            mosi_q  <= {mosi_q[0], mosi_i};
            dc_q    <= {dc_q[0], dc_i};
            prst_q  <= {prst_q[1:0], panel_rst_ni};
            valid_q <= 1'b0;
            if (!prst_q[1]) begin
                cnt_q <= '0;
            end else if (rise) begin
                shift_q <= shift_next;
                cnt_q   <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    data_q   <= shift_next;
                    dc_out_q <= dc_q[1];
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign data_o    = data_q;
    assign dc_o      = dc_out_q;
    assign valid_o   = valid_q;
    assign link_up_o = prst_q[1];

endmodule

// File: rtl/oled_spi_sink.sv
// SSD1306-style command decoder and framebuffer writer fed by an SPI byte receiver.
// Define OLED_SINK_HADDR_EN to honour horizontal addressing selected via 0x20.
module oled_spi_sink
    import oled_pkg::*;
(
    input logic            clk,
    input logic            rst,
    oled_spi_sink_if.slave bus
);

    logic [7:0]         rx_data;
    logic               rx_dc;
    logic               rx_valid;
    logic               link_up;

    state_e             state_q;
    logic [7:0]         op_q;
    logic [2:0]         page_q;
    logic [6:0]         col_q;
    logic               fb_wren_q;
    logic [FbAddrW-1:0] fb_wraddress_q;
    logic [7:0]         fb_data_q;
    logic               cmd_valid_q;
    logic [7:0]         cmd_byte_q;
    logic               display_on_q;
    logic [7:0]         contrast_q;
`ifdef OLED_SINK_HADDR_EN
    logic               hmode_q;
`endif

    spi_rx_byte u_rx (
        .clk          (clk),
        .rst          (rst),
        .sclk_i       (bus.oled_sclk),
        .mosi_i       (bus.oled_mosi),
        .dc_i         (bus.oled_dc),
        .panel_rst_ni (bus.oled_rst),
        .data_o       (rx_data),
        .dc_o         (rx_dc),
        .valid_o      (rx_valid),
        .link_up_o    (link_up)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= '0;
            page_q         <= '0;
            col_q          <= '0;
            fb_wren_q      <= 1'b0;
            fb_wraddress_q <= '0;
            fb_data_q      <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_byte_q     <= '0;
            display_on_q   <= 1'b0;
            contrast_q     <= 8'h7F;
`ifdef OLED_SINK_HADDR_EN
            hmode_q        <= 1'b0;
`endif
        end else begin
            fb_wren_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            if (!link_up) begin
                state_q <= StIdle;
                page_q  <= '0;
                col_q   <= '0;
            end else if (rx_valid && rx_dc) begin
                fb_wren_q      <= 1'b1;
                fb_data_q      <= rx_data;
                fb_wraddress_q <= {page_q, col_q};
                col_q          <= col_q + 7'd1;
                state_q        <= StIdle;
`ifdef OLED_SINK_HADDR_EN
                if (hmode_q && col_q == 7'h7F) page_q <= page_q + 3'd1;
`endif
            end else if (rx_valid) begin
                cmd_valid_q <= 1'b1;
                cmd_byte_q  <= rx_data;
                unique case (state_q)
                    StIdle: begin
                        op_q <= rx_data;
                        if (rx_data[7:3] == 5'b10110) begin
                            page_q <= rx_data[2:0];
                        end else if (rx_data[7:4] == 4'h0) begin
                            col_q[3:0] <= rx_data[3:0];
                        end else if (rx_data[7:3] == 5'b00010) begin
                            col_q[6:4] <= rx_data[2:0];
                        end else if (rx_data == OpDisplayOff) begin
                            display_on_q <= 1'b0;
                        end else if (rx_data == OpDisplayOn) begin
                            display_on_q <= 1'b1;
                        end else if (is_one_arg_op(rx_data) || is_two_arg_op(rx_data)) begin
                            state_q <= StArg1;
                        end
                    end
                    StArg1: begin
                        if (op_q == OpSetContrast) contrast_q <= rx_data;
`ifdef OLED_SINK_HADDR_EN
                        if (op_q == OpAddrMode) begin
                            if (rx_data == 8'h00) hmode_q <= 1'b1;
                            else if (rx_data == 8'h01 || rx_data == 8'h02) hmode_q <= 1'b0;
                        end
`endif
                        state_q <= is_two_arg_op(op_q) ? StArg2 : StIdle;
                    end
                    StArg2:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.fb_wren      = fb_wren_q;
    assign bus.fb_wraddress = fb_wraddress_q;
    assign bus.fb_data      = fb_data_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_byte     = cmd_byte_q;
    assign bus.display_on   = display_on_q;
    assign bus.contrast     = contrast_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Scoreboard bench for oled_spi_sink: each sent byte queues its expected strobe,
// which is popped and compared when the DUT pulses fb_wren or cmd_valid.
module tb_oled_spi_sink;

    typedef struct packed {
        logic       is_data;
        logic [9:0] addr;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    exp_t exp_q[$];

    oled_spi_sink_if bus ();

    oled_spi_sink dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Any strobe must match the head of the scoreboard and arrive 4 clk after the
    // 8th pin edge (2 sync stages + 2 cycles after detection).
    always @(negedge clk) begin
        if (bus.fb_wren || bus.cmd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {bus.fb_wren, bus.cmd_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("kind", {bus.fb_wren, bus.cmd_valid}, e.is_data ? 32'd2 : 32'd1);
                check("latency", cyc - rise_cyc, 32'd4);
                if (e.is_data) begin
                    check("fb_wraddress", bus.fb_wraddress, e.addr);
                    check("fb_data", bus.fb_data, e.val);
                end else begin
                    check("cmd_byte", bus.cmd_byte, e.val);
                end
            end
        end
    end

    task automatic spi_bits(input logic dc, input logic [7:0] v, input int nbits);
        bus.oled_dc = dc;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.oled_mosi = v[i];
            repeat (4) @(posedge clk);
            #1 bus.oled_sclk = 1'b1;
            rise_cyc = cyc;
            repeat (4) @(posedge clk);
            #1 bus.oled_sclk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [7:0] v);
        exp_q.push_back('{is_data: 1'b0, addr: 10'h0, val: v});
        spi_bits(1'b0, v, 8);
    endtask

    task automatic send_data(input logic [7:0] v, input logic [9:0] addr);
        exp_q.push_back('{is_data: 1'b1, addr: addr, val: v});
        spi_bits(1'b1, v, 8);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.oled_sclk = 1'b0;
        bus.oled_mosi = 1'b0;
        bus.oled_dc   = 1'b0;
        bus.oled_rst  = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_fb_wren", bus.fb_wren, 32'd0);
        check("rst_cmd_valid", bus.cmd_valid, 32'd0);
        check("rst_fb_wraddress", bus.fb_wraddress, 32'd0);
        check("rst_fb_data", bus.fb_data, 32'd0);
        check("rst_cmd_byte", bus.cmd_byte, 32'd0);
        check("rst_display_on", bus.display_on, 32'd0);
        check("rst_contrast", bus.contrast, 32'h7F);

        // Page 2, col 0x35.
        send_cmd(8'hB2);
        send_cmd(8'h05);
        send_cmd(8'h13);
        send_data(8'hA5, 10'h135);

        // Contrast argument and display on.
        send_cmd(8'h81);
        send_cmd(8'h40);
        send_cmd(8'hAF);
        settle();
        check("contrast", bus.contrast, 32'h40);
        check("display_on", bus.display_on, 32'd1);

        // Page-mode column wrap over 129 bytes.
        send_cmd(8'hB0);
        send_cmd(8'h00);
        send_cmd(8'h10);
        for (int i = 0; i < 129; i++) begin
            logic [7:0] v;
            v = 8'(i) ^ 8'h5A;
            send_data(v, 10'(i % 128));
        end

        // Panel reset mid-byte discards the partial byte and clears page/col.
        send_cmd(8'hB3);
        spi_bits(1'b1, 8'hFF, 5);
        #1 bus.oled_rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.oled_rst = 1'b1;
        repeat (6) @(posedge clk);
        send_data(8'h3C, 10'h000);

        // Data inside an argument slot returns to idle; next opcode is decoded.
        send_cmd(8'h8D);
        send_data(8'h14, 10'h001);
        send_cmd(8'hB1);
        send_data(8'h77, 10'h082);

        // Two-argument opcode: arguments look like column commands but are consumed.
        send_cmd(8'h21);
        send_cmd(8'h0F);
        send_cmd(8'h17);
        send_data(8'h99, 10'h083);
        send_cmd(8'hAE);
        settle();
        check("display_off", bus.display_on, 32'd0);

`ifdef OLED_SINK_HADDR_EN
        send_cmd(8'h20);
        send_cmd(8'h00);
        send_cmd(8'hB7);
        send_cmd(8'h00);
        send_cmd(8'h10);
        for (int i = 0; i < 129; i++) begin
            logic [9:0] a;
            a = (i < 128) ? (10'h380 + 10'(i)) : 10'h000;
            send_data(8'(i), a);
        end
`else
        // Address-mode argument is swallowed; page mode stays in force.
        send_cmd(8'h20);
        send_cmd(8'h00);
        send_cmd(8'hB7);
        send_cmd(8'h0F);
        send_cmd(8'h17);
        send_data(8'h11, 10'h3FF);
        send_data(8'h22, 10'h380);
`endif

        // System reset mid-byte: no strobe may follow, state returns to defaults.
        send_cmd(8'h81);
        send_cmd(8'h10);
        send_cmd(8'hAF);
        spi_bits(1'b1, 8'hFF, 3);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        check("rst2_contrast", bus.contrast, 32'h7F);
        check("rst2_display_on", bus.display_on, 32'd0);
        send_data(8'hC3, 10'h000);

        settle();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
